// File: rtl/prbs_checker.sv
// Self-synchronising PRBS receiver: seeds from the stream, verifies, locks, detects loss, counts bits/errors.
// Optional build macro PRBS_CHK_FLYWHEEL_EN: while locked, predicted bits feed the local register.
module prbs_checker #(
    parameter int unsigned N           = 3,
    parameter logic [1:N]  TAPS        = 3'b011,
    parameter int unsigned SYNC_COUNT  = 8,
    parameter int unsigned WIN         = 64,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned SEED_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MATCH_W = 8;
    localparam int unsigned WIN_W   = $clog2(WIN);
    localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t             r_state;
    logic [1:N]         r_c;
    logic [SEED_W-1:0]  r_seed_cnt;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [WERR_W-1:0]  r_win_err;
    logic               r_locked;
    logic               r_err_pulse;
    logic               r_lock_lost;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    state_t             w_state_nxt;
    logic [1:N]         w_c_nxt;
    logic [SEED_W-1:0]  w_seed_nxt;
    logic [MATCH_W-1:0] w_match_nxt;
    logic [WIN_W-1:0]   w_win_nxt;
    logic [WERR_W-1:0]  w_werr_nxt;
    logic [WERR_W-1:0]  w_werr_sum;
    logic               w_locked_nxt;
    logic               w_err_pulse_nxt;
    logic               w_lock_lost_nxt;
    logic [CNT_W-1:0]   w_bit_nxt;
    logic [CNT_W-1:0]   w_err_nxt;
    logic               w_exp;
    logic               w_mis;

    // Predicted next stream bit from the local register and the mismatch against the received bit.
    assign w_exp = ^(r_c & TAPS);
    assign w_mis = in_bit ^ w_exp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SEED;
            r_c         <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
            r_bit_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_c         <= w_c_nxt;
            r_seed_cnt  <= w_seed_nxt;
            r_match_cnt <= w_match_nxt;
            r_win_cnt   <= w_win_nxt;
            r_win_err   <= w_werr_nxt;
            r_locked    <= w_locked_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_err_cnt   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_c_nxt         = r_c;
        w_seed_nxt      = r_seed_cnt;
        w_match_nxt     = r_match_cnt;
        w_win_nxt       = r_win_cnt;
        w_werr_nxt      = r_win_err;
        w_err_pulse_nxt = 1'b0;
        w_lock_lost_nxt = 1'b0;
        w_bit_nxt       = r_bit_cnt;
        w_err_nxt       = r_err_cnt;
        w_werr_sum      = r_win_err + WERR_W'(w_mis);

        if (in_valid) begin
            unique case (r_state)
                ST_SEED: begin
                    w_c_nxt = {in_bit, r_c[1:N-1]};
                    if (r_seed_cnt == SEED_W'(N - 1)) begin
                        // An all-zero seed can never predict a PRBS, so refill instead.
                        w_seed_nxt = '0;
                        if (w_c_nxt != '0) begin
                            w_state_nxt = ST_VERIFY;
                            w_match_nxt = '0;
                        end
                    end else begin
                        w_seed_nxt = r_seed_cnt + SEED_W'(1);
                    end
                end
                ST_VERIFY: begin
                    w_c_nxt = {in_bit, r_c[1:N-1]};
                    if (w_mis) begin
                        w_state_nxt = ST_SEED;
                        w_seed_nxt  = '0;
                    end else if (r_match_cnt == MATCH_W'(SYNC_COUNT - 1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_match_nxt = '0;
                        w_win_nxt   = '0;
                        w_werr_nxt  = '0;
                    end else begin
                        w_match_nxt = r_match_cnt + MATCH_W'(1);
                    end
                end
                ST_LOCKED: begin
`ifdef PRBS_CHK_FLYWHEEL_EN
                    w_c_nxt = {w_exp, r_c[1:N-1]};
`else
                    w_c_nxt = {in_bit, r_c[1:N-1]};
`endif
                    if (r_bit_cnt != '1) begin
                        w_bit_nxt = r_bit_cnt + CNT_W'(1);
                    end
                    if (w_mis) begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_cnt != '1) begin
                            w_err_nxt = r_err_cnt + CNT_W'(1);
                        end
                    end
                    // Loss takes priority over the end-of-window restart.
                    if (w_werr_sum == WERR_W'(LOSS_THRESH)) begin
                        w_state_nxt     = ST_SEED;
                        w_seed_nxt      = '0;
                        w_lock_lost_nxt = 1'b1;
                        w_win_nxt       = '0;
                        w_werr_nxt      = '0;
                    end else if (r_win_cnt == WIN_W'(WIN - 1)) begin
                        w_win_nxt  = '0;
                        w_werr_nxt = '0;
                    end else begin
                        w_win_nxt  = r_win_cnt + WIN_W'(1);
                        w_werr_nxt = w_werr_sum;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEED;
                    w_seed_nxt  = '0;
                end
            endcase
        end

        if (clr_cnt) begin
            w_bit_nxt = '0;
            w_err_nxt = '0;
        end

        w_locked_nxt = (w_state_nxt == ST_LOCKED);
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign lock_lost = r_lock_lost;
    assign bit_count = r_bit_cnt;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: lock-acquisition table, scripted corner sequences and randomized stream vs a reference model.
`timescale 1ns/1ps
module tb_prbs_checker;

    localparam int unsigned N           = 3;
    localparam logic [1:N]  TAPS        = 3'b011;
    localparam int unsigned SYNC_COUNT  = 8;
    localparam int unsigned WIN         = 64;
    localparam int unsigned LOSS_THRESH = 8;
    localparam int unsigned CNT_W       = 8;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;
`ifdef PRBS_CHK_FLYWHEEL_EN
    localparam int          ERRS_PER_HIT = 1;
`else
    localparam int          ERRS_PER_HIT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_bit;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic             lock_lost;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    prbs_checker #(
        .N(N), .TAPS(TAPS), .SYNC_COUNT(SYNC_COUNT), .WIN(WIN),
        .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
        .bit_count(bit_count), .err_count(err_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int obs_pulses;
    int obs_lost;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of the last N register bits (index 0 newest) and phase bookkeeping.
    typedef enum int {P_SEED, P_VERIFY, P_LOCKED} phase_t;
    phase_t m_phase;
    bit     hist[$];
    int     m_seed, m_match, m_wpos, m_werr, m_bc, m_ec;
    bit     m_pulse, m_lost;

    function automatic bit m_predict();
        bit p = 1'b0;
        for (int k = 1; k <= int'(N); k++) if (TAPS[k]) p ^= hist[k-1];
        return p;
    endfunction

    function automatic void m_push(input bit b);
        hist.push_front(b);
        void'(hist.pop_back());
    endfunction

    function automatic void model_reset();
        hist = {};
        for (int k = 0; k < int'(N); k++) hist.push_front(1'b0);
        m_phase = P_SEED;
        m_seed = 0; m_match = 0; m_wpos = 0; m_werr = 0;
        m_bc = 0; m_ec = 0; m_pulse = 1'b0; m_lost = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit c);
        bit p, mis, nz;
        m_pulse = 1'b0;
        m_lost  = 1'b0;
        if (v) begin
            p   = m_predict();
            mis = b ^ p;
            case (m_phase)
                P_SEED: begin
                    m_push(b);
                    m_seed++;
                    if (m_seed == int'(N)) begin
                        m_seed = 0;
                        nz = 1'b0;
                        foreach (hist[k]) nz |= hist[k];
                        if (nz) begin m_phase = P_VERIFY; m_match = 0; end
                    end
                end
                P_VERIFY: begin
                    m_push(b);
                    if (mis) begin
                        m_phase = P_SEED; m_seed = 0;
                    end else begin
                        m_match++;
                        if (m_match == int'(SYNC_COUNT)) begin
                            m_phase = P_LOCKED; m_wpos = 0; m_werr = 0;
                        end
                    end
                end
                default: begin
`ifdef PRBS_CHK_FLYWHEEL_EN
                    m_push(p);
`else
                    m_push(b);
`endif
                    if (m_bc < CNT_MAX) m_bc++;
                    if (mis) begin
                        if (m_ec < CNT_MAX) m_ec++;
                        m_pulse = 1'b1;
                        m_werr++;
                    end
                    if (m_werr == int'(LOSS_THRESH)) begin
                        m_phase = P_SEED; m_seed = 0; m_lost = 1'b1;
                    end else if (m_wpos == int'(WIN) - 1) begin
                        m_wpos = 0; m_werr = 0;
                    end else begin
                        m_wpos++;
                    end
                end
            endcase
        end
        if (c) begin m_bc = 0; m_ec = 0; end
    endfunction

    // Reference generator: q[N] is the transmitted bit, feedback enters at q[1].
    logic [1:N] gq;

    task automatic gen_step(output bit b);
        b  = gq[N];
        gq = {^(gq & TAPS), gq[1:N-1]};
    endtask

    task automatic step(input bit v, input bit b, input bit c);
        in_valid = v; in_bit = b; clr_cnt = c;
        @(posedge clk);
        #1;
        model_step(v, b, c);
        chk("locked", 32'(locked), 32'(m_phase == P_LOCKED));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("lock_lost", 32'(lock_lost), 32'(m_lost));
        chk("bit_count", 32'(bit_count), 32'(m_bc));
        chk("err_count", 32'(err_count), 32'(m_ec));
        obs_pulses += int'(err_pulse);
        obs_lost   += int'(lock_lost);
    endtask

    task automatic send(input bit v, input bit inv, input bit c);
        bit b;
        if (v) begin
            gen_step(b);
            step(1'b1, b ^ inv, c);
        end else begin
            step(1'b0, 1'($urandom), c);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
        chk({tag, "_bit_count"}, 32'(bit_count), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    typedef struct {
        bit v;
        bit b;
        bit exp_locked;
        int exp_bc;
        int exp_ec;
    } vec_t;
    vec_t tbl[16];

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, cnt;
        bit dummy;

        // Generator stream from init 001 is 1001011...; bit 11 is the locking edge.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 0, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 0, 0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 0, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 0, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1, 0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 2, 0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 3, 0};

        obs_pulses = 0; obs_lost = 0;
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Lock acquisition table
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].b, 1'b0);
            chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
            chk($sformatf("tbl%0d_bit_count", i), 32'(bit_count), 32'(tbl[i].exp_bc));
            chk($sformatf("tbl%0d_err_count", i), 32'(err_count), 32'(tbl[i].exp_ec));
        end
        gq = 3'b001;
        repeat (14) gen_step(dummy);

        // Clean run up to 100 checked bits
        obs_pulses = 0;
        repeat (97) send(1'b1, 1'b0, 1'b0);
        chk("clean_bit_count", 32'(bit_count), 32'd100);
        chk("clean_err_count", 32'(err_count), 32'd0);
        chk("clean_pulses", 32'(obs_pulses), 32'd0);

        // Single channel error
        obs_pulses = 0;
        send(1'b1, 1'b1, 1'b0);
        repeat (10) send(1'b1, 1'b0, 1'b0);
        chk("single_err_count", 32'(err_count), 32'(ERRS_PER_HIT));
        chk("single_pulses", 32'(obs_pulses), 32'(ERRS_PER_HIT));
        chk("single_locked", 32'(locked), 32'd1);

        // Clear coincident with a valid bit
        send(1'b1, 1'b0, 1'b1);
        chk("clr_bit_count", 32'(bit_count), 32'd0);
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_locked", 32'(locked), 32'd1);
        repeat (5) send(1'b1, 1'b0, 1'b0);

        // Error burst inside one window until loss of lock
        cnt = 0;
        while (m_wpos != 0 && cnt < 2 * int'(WIN)) begin
            send(1'b1, 1'b0, 1'b0);
            cnt++;
        end
        base = m_ec;
        obs_lost = 0;
        for (int k = 0; k < 64; k++) begin
            send(1'b1, 1'((k % 4) == 0), 1'b0);
            if (lock_lost) break;
        end
        chk("loss_pulses", 32'(obs_lost), 32'd1);
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_err_delta", 32'(int'(err_count) - base), 32'(LOSS_THRESH));
        cnt = 0;
        while (!locked && cnt < 40) begin
            send(1'b1, 1'b0, 1'b0);
            cnt++;
        end
        chk("relock_bits", 32'(cnt), 32'(N + SYNC_COUNT));

        // Saturation of bit_count
        repeat (300) send(1'b1, 1'b0, 1'b0);
        chk("sat_bit_count", 32'(bit_count), 32'(CNT_MAX));

        // Randomized stream with gaps, injected errors and occasional clears
        for (int k = 0; k < 3000; k++) begin
            send(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        // All-zero stream after reset never locks
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        obs_lost = 0;
        repeat (50) step(1'b1, 1'b0, 1'b0);
        check_all_zero("zeros");

        // Asynchronous reset while locked with nonzero counters
        gq = 3'b001;
        repeat (30) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        repeat (2) send(1'b1, 1'b0, 1'b0);
        chk("pre_reset_locked", 32'(locked), 32'd1);
        chk("pre_reset_err_count", 32'(err_count != '0), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the team's LFSR pattern generator: consumes the serial PRBS bit stream, self-synchronises to it, then counts checked bits and bit errors for error-rate analysis.
- Sits at the far end of the link under test; the generator drives the stream at one bit per valid cycle.
- Stream convention: each valid bit is the generator's last register bit, q[N], sampled before the shift.

Parameters:
- N, 3: LFSR length; must equal the generator's N.
- TAPS, 3'b011: tap mask [1:N]; must equal the generator's TAPS.
- SYNC_COUNT, 8: consecutive correct predictions required to declare lock (1..255).
- WIN, 64: loss-detection window length in valid bits while locked (2..65535).
- LOSS_THRESH, 8: errors within one window that force loss of lock (1..WIN).
- CNT_W, 32: width of bit_count and err_count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  received serial PRBS bit.
- clr_cnt  in  1  synchronous clear of bit_count and err_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse: the previous sampled bit mismatched while LOCKED.
- lock_lost  out  1  one-cycle pulse on a LOCKED-to-SEED transition.
- bit_count  out  CNT_W  bits checked while LOCKED; saturates at all-ones.
- err_count  out  CNT_W  errored bits while LOCKED; saturates at all-ones.

Behaviour:
- Local register c[1:N]; expected bit e = ^(c & TAPS); mismatch m = in_bit ^ e. This gives e = stream bit t+N for c holding bits t..t+N-1 with c[1] newest.
- Only in_valid cycles advance state, registers or counters. All outputs are registered.
- Reset (asynchronous, any time, including mid-lock):
  - state = SEED; c = 0; seed count = 0; match count = 0.
  - All outputs 0.
  - Window counters = 0.
- SEED:
  - c <= {in_bit, c[1:N-1]} each valid bit.
  - After N valid bits: if the resulting c is nonzero, go to VERIFY with match count 0.
  - If the resulting c is all-zero, restart SEED (seed count 0). An all-zero stream never locks.
- VERIFY:
  - Shift the received bit into c.
  - m=0: increment match count. On reaching SYNC_COUNT, go to LOCKED; locked rises on that edge.
  - m=1: go to SEED, seed count 0; c keeps the shifted value and is overwritten as the seed refills.
  - bit_count and err_count do not change in SEED or VERIFY.
- LOCKED:
  - Each valid bit: bit_count +1; if m=1, err_count +1 and err_pulse=1 on the next cycle.
  - Shift rule into c is defined under Optional Feature.
  - Window counter runs 0..WIN-1 over valid bits; window error count increments on m=1.
  - When window error count reaches LOSS_THRESH: go to SEED, locked falls and lock_lost pulses on the same edge. Counters retain their values.
  - On the last bit of a window, window counter and window error count reset to 0. If the threshold is reached on that same bit, loss wins.
- Latency: a bit sampled at edge k is reflected in bit_count, err_count and err_pulse at edge k.
- With a matching generator stream, locked rises on the edge sampling valid bit N+SYNC_COUNT.
- clr_cnt=1: both counters become 0 on the next edge. A bit coincident with clr_cnt is not counted (clear wins). Lock state is unaffected.
- Saturation: counters hold at 2^CNT_W-1; no wrap.

Optional Feature:
- Macro PRBS_CHK_FLYWHEEL_EN.
- Defined: in LOCKED, c shifts in e (the predicted bit), not in_bit, so one channel error produces exactly one counted error.
- Undefined: c always shifts in in_bit, so one channel error is counted once plus once per set tap it passes through (self-synchronising checker behaviour).
- SEED and VERIFY behaviour is identical in both builds.

Test Plan:
- Reset, then generator stream (N=3, TAPS=011, init 001), in_valid=1 every cycle -> locked rises on the edge of valid bit 11; bit_count=0 and err_count=0 at that edge.
- Locked, 100 clean bits -> bit_count=100, err_count=0, err_pulse never asserted.
- Locked, invert one bit -> FLYWHEEL_EN defined: err_count=1, a single err_pulse. Undefined: err_count=3 on three separate bits (the errored bit plus taps c[2], c[3]).
- Locked, invert 8 bits inside one 64-bit window -> lock_lost pulses once and locked=0 on the 8th error edge; clean stream afterwards re-locks after 11 further valid bits.
- All-zero input for 50 bits after reset -> locked stays 0, counters stay 0.
- Locked with counters nonzero: assert clr_cnt with a valid bit -> both counters 0 next cycle, locked stays 1. Then assert reset mid-stream -> all outputs 0 immediately, asynchronously.
